// File: rtl/cpu_run_controller.sv
// Self-timed load/run/dump sequencer around the cpu core: streams the program and
// initial data into the core's memories, runs it for a fixed cycle count, streams data back.
module cpu_run_controller #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    input  logic             out_ready,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    // Handshakes: a word moves on a cycle where valid && ready are both high at the
    // clock edge; a producer holds valid and data stable until that happens.
    typedef enum logic [2:0] {
        IDLE, LOAD_I, LOAD_D, RUN, DUMP_REQ, DUMP_OUT, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] imem_n, dmem_n, dump_n, idx;
    logic [RUN_W-1:0] run_n, cyc;
    logic [63:0]      idx_ext;

    // First non-empty phase at or after position `from` (0=LOAD_I .. 3=DUMP).
    function automatic state_t next_phase(input logic [1:0] from, input logic has_i,
                                          input logic has_d, input logic has_r,
                                          input logic has_u);
        next_phase = DONE;
        if (has_u)                   next_phase = DUMP_REQ;
        if (has_r && from <= 2'd2)   next_phase = RUN;
        if (has_d && from <= 2'd1)   next_phase = LOAD_D;
        if (has_i && from == 2'd0)   next_phase = LOAD_I;
    endfunction

    assign idx_ext = {{(64-CNT_W){1'b0}}, idx};

    always_comb begin
        in_ready    = (state == LOAD_I) || (state == LOAD_D);
        cpu_enable  = (state == RUN);
        busy        = (state != IDLE) && (state != DONE);
        done        = (state == DONE);
        ren_ext     = 1'b0;
        wen_ext     = 1'b0;
        addr_ext    = 64'd0;
        wdata_ext   = 32'd0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = 64'd0;
        wdata_ext_2 = 64'd0;
        case (state)
            LOAD_I: begin
                wen_ext   = in_valid;
                addr_ext  = idx_ext << 2;
                wdata_ext = in_data[31:0];
            end
            LOAD_D: begin
                wen_ext_2   = in_valid;
                addr_ext_2  = idx_ext << 3;
                wdata_ext_2 = in_data;
            end
            DUMP_REQ: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = idx_ext << 3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            imem_n    <= '0;
            dmem_n    <= '0;
            dump_n    <= '0;
            run_n     <= '0;
            idx       <= '0;
            cyc       <= '0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        imem_n    <= imem_words;
                        dmem_n    <= dmem_words;
                        run_n     <= run_cycles;
                        dump_n    <= dump_words;
                        idx       <= '0;
                        cyc       <= '0;
                        out_valid <= 1'b0;
                        state     <= next_phase(2'd0, |imem_words, |dmem_words,
                                                |run_cycles, |dump_words);
                    end
                end
                LOAD_I: begin
                    if (in_valid) begin
                        if (idx == imem_n - CNT_W'(1)) begin
                            idx   <= '0;
                            state <= next_phase(2'd1, 1'b0, |dmem_n, |run_n, |dump_n);
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (in_valid) begin
                        if (idx == dmem_n - CNT_W'(1)) begin
                            idx   <= '0;
                            state <= next_phase(2'd2, 1'b0, 1'b0, |run_n, |dump_n);
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (cyc == run_n - RUN_W'(1)) begin
                        cyc   <= '0;
                        state <= next_phase(2'd3, 1'b0, 1'b0, 1'b0, |dump_n);
                    end else begin
                        cyc <= cyc + RUN_W'(1);
                    end
                end
                DUMP_REQ: begin
                    // Read data for the address presented this cycle lands in out_data
                    // on the edge that enters DUMP_OUT.
                    out_data  <= rdata_ext_2;
                    out_valid <= 1'b1;
                    state     <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == dump_n - CNT_W'(1)) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx   <= idx + CNT_W'(1);
                            state <= DUMP_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: behavioural memories plus a stand-in core that
// increments data word 0 on every enabled cycle, checked against a phase-level model.
module tb_cpu_run_controller;

  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] imem_words = '0, dmem_words = '0, dump_words = '0;
  logic [31:0] run_cycles = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic [31:0] wdata_ext;

  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  logic        mem_init = 1'b0;
  logic [63:0] exp_q [$];
  logic [31:0] prog [4] = '{32'h0050_0093, 32'h0010_3023, 32'h0000_0013, 32'h0000_0013};

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_controller #(.CNT_W(16), .RUN_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
    .dump_words(dump_words), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  // clock / memories / stand-in core
  always #5 clk = ~clk;

  assign rdata_ext_2 = ren_ext_2 ? dmem[addr_ext_2[8:3]] : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        dmem[i] <= PAT | 64'(i);
        imem[i] <= 32'd0;
      end
    end else begin
      if (wen_ext) imem[addr_ext[7:2]] <= wdata_ext;
      if (wen_ext_2) dmem[addr_ext_2[8:3]] <= wdata_ext_2;
      else if (cpu_enable) dmem[0] <= dmem[0] + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready_valid_en"}, {61'd0, in_ready, out_valid, cpu_enable}, 64'd0);
    check({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_enables"}, {60'd0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
    check({tag, "_addr_or"}, addr_ext | addr_ext_2 | wdata_ext_2 | 64'(wdata_ext), 64'd0);
  endtask

  // driver: full start -> done sequence with host-side load and dump streams
  task automatic run_seq(input int ni, input int nd, input int nr, input int nu,
                         input int gap, input int stall, input bit use_prog);
    logic [63:0] load_q [$];
    logic [31:0] ref_i [64];
    logic [63:0] ref_d [64];
    logic [63:0] w;
    int k, nh, en_cnt, first_en, last_en, first_ren, first_ov, last_hs, wait_ctr;
    bit hs_in, hs_out, finished;

    @(negedge clk); mem_init = 1'b1;
    @(negedge clk); mem_init = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_d[i] = PAT | 64'(i);
      ref_i[i] = 32'd0;
    end
    for (int i = 0; i < ni; i++) begin
      w = use_prog ? {32'd0, prog[i % 4]} : {$urandom, $urandom};
      load_q.push_back(w);
      ref_i[i] = w[31:0];
    end
    for (int i = 0; i < nd; i++) begin
      w = {$urandom, $urandom};
      load_q.push_back(w);
      ref_d[i] = w;
    end
    ref_d[0] = ref_d[0] + 64'(nr);
    exp_q.delete();
    for (int i = 0; i < nu; i++) exp_q.push_back(ref_d[i % 64]);

    imem_words = 16'(ni); dmem_words = 16'(nd); run_cycles = 32'(nr); dump_words = 16'(nu);
    start = 1'b1;
    k = 0; nh = 0; en_cnt = 0; first_en = -1; last_en = -1; first_ren = -1; first_ov = -1;
    last_hs = 0; wait_ctr = 0; hs_in = 1'b0; finished = 1'b0;

    while (k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        imem_words = 16'($urandom); dmem_words = 16'($urandom);
        run_cycles = $urandom; dump_words = 16'($urandom);
      end
      if (hs_in) begin
        void'(load_q.pop_front());
        in_valid = 1'b0;
        nh++;
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (!in_valid)
        in_valid = (load_q.size() > 0) && (gap == 0 || $urandom_range(0, 2) == 0);
      in_data = in_valid ? load_q[0] : {$urandom, $urandom};
      if (out_valid) out_ready = (wait_ctr >= stall);
      else begin
        out_ready = 1'($urandom_range(0, 1));
        wait_ctr = 0;
      end
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;

      check("ren_ext_tied", {63'd0, ren_ext}, 64'd0);
      check("port_exclusive", {63'd0, (wen_ext_2 && ren_ext_2) ||
            ((wen_ext || wen_ext_2 || ren_ext_2) && cpu_enable)}, 64'd0);
      if (hs_in && nh < ni) begin
        check("imem_wen", {62'd0, wen_ext, wen_ext_2}, 64'd2);
        check("imem_addr", addr_ext, 64'(nh) * 4);
        check("imem_wdata", 64'(wdata_ext), 64'(load_q[0][31:0]));
      end else if (hs_in) begin
        check("dmem_wen", {62'd0, wen_ext, wen_ext_2}, 64'd1);
        check("dmem_addr", addr_ext_2, 64'(nh - ni) * 8);
        check("dmem_wdata", wdata_ext_2, load_q[0]);
      end else begin
        check("no_write", {62'd0, wen_ext, wen_ext_2}, 64'd0);
      end
      if (hs_out) begin
        check("dump_word", out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hEEEE);
        wait_ctr = 0;
      end else if (out_valid) begin
        check("dump_hold", out_data, (exp_q.size() > 0) ? exp_q[0] : 64'hEEEE);
        check("dump_no_reread", {63'd0, ren_ext_2}, 64'd0);
        wait_ctr++;
      end
      if (cpu_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (ren_ext_2 && first_ren < 0) first_ren = k;
      if (out_valid && first_ov < 0) first_ov = k;
      if (hs_in) last_hs = k;
    end

    in_valid = 1'b0;
    check("finished", {63'd0, finished}, 64'd1);
    check("done_not_busy", {62'd0, busy, done}, 64'd1);
    check("loads_consumed", 64'(nh), 64'(ni + nd));
    check("dumps_consumed", 64'(exp_q.size()), 64'd0);
    check("enable_count", 64'(en_cnt), 64'(nr));
    if (nr > 0) begin
      check("enable_contig", 64'(last_en - first_en + 1), 64'(nr));
      check("load_to_run", 64'(first_en), 64'((ni + nd > 0) ? last_hs + 1 : 1));
      if (nu > 0) begin
        check("run_to_req", 64'(first_ren), 64'(last_en + 1));
        check("run_to_valid", 64'(first_ov), 64'(last_en + 2));
      end
    end
    if (gap == 0 && stall == 0)
      check("total_latency", 64'(k), 64'(ni + nd + nr + 2 * nu + 1));
    for (int i = 0; i < ni; i++) check("imem_content", 64'(imem[i]), 64'(ref_i[i]));
    for (int i = 0; i < ((nd > 0) ? nd : 1); i++) check("dmem_content", dmem[i], ref_d[i]);
  endtask

  initial begin
    // reset
    #12;
    check_idle_outputs("reset");
    check("reset_out_data", out_data, 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_seq(3, 2, 0, 2, 0, 0, 0);
    run_seq(4, 0, 12, 1, 0, 0, 1);
    run_seq(0, 0, 0, 0, 0, 0, 0);
    run_seq(1, 2, 2, 3, 0, 5, 0);
    run_seq(2, 5, 1, 2, 1, 0, 0);

    // asynchronous reset in the third of ten run cycles
    @(negedge clk);
    imem_words = 16'd0; dmem_words = 16'd0; dump_words = 16'd0; run_cycles = 32'd10;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("run_cycle3_enable", {62'd0, cpu_enable, busy}, 64'd3);
    #1 arst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk); arst_n = 1'b1;
    run_seq(2, 2, 3, 2, 0, 0, 0);

    for (int t = 0; t < 6; t++)
      run_seq($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 8),
              $urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, 3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
